phys_reg_file_sweep: RTL
========================

// Module: phys_reg_file_sweep
// PURPOSE
// Parametrised physical register file for the OoO core: N-read/M-write data array, ready-bit scoreboard, same-cycle write bypass.
// Clears itself with a post-reset init sweep instead of a wide reset, and adds a handshaked engine that streams architectural state
// (through a caller-supplied arch->phys map) to the test/DPI side. Sits between rename/dispatch (alloc, reads) and writeback (writes).
// PARAMETERS
// NUM_PREGS     96          physical registers (>= NUM_ARCH+1); PB = $clog2(NUM_PREGS)
// NUM_ARCH      32          architectural registers; AB = $clog2(NUM_ARCH)
// DATA_W        32          register width
// READ_PORTS    8           combinational read ports
// WRITE_PORTS   4           writeback ports
// ALLOC_PORTS   4           rename allocation (ready-clear) ports
// SP_INIT       32'h0       value loaded into preg 29 by the init sweep
// RA_INIT       32'h0       value loaded into preg 31 by the init sweep
// MAGIC         32'h0       compare value for magic
// PORTS
// clk            in   1                   clock
// rst            in   1                   asynchronous, active-low reset
// rd_addr        in   PB x READ_PORTS     read addresses
// rd_data        out  DATA_W x READ_PORTS read data (bypassed)
// rd_ready       out  READ_PORTS          operand ready
// wr_en          in   WRITE_PORTS         writeback valid; also sets ready
// wr_addr        in   PB x WRITE_PORTS    writeback preg
// wr_data        in   DATA_W x WRITE_PORTS writeback data
// alloc_en       in   ALLOC_PORTS         new destination allocated; clears ready
// alloc_addr     in   PB x ALLOC_PORTS    allocated preg
// init_busy      out  1                   init sweep in progress
// dump_start     in   1                   pulse: begin architectural dump
// dump_map       in   PB x NUM_ARCH       arch->preg map, sampled on accepted dump_start
// dump_valid     out  1                   dump beat valid
// dump_ready     in   1                   consumer accepts beat
// dump_idx       out  AB                  arch register index of beat
// dump_data      out  DATA_W              value of regs[map[dump_idx]]
// dump_busy      out  1                   dump in progress
// magic_preg     in   PB                  preg currently holding arch $v0
// magic          out  1                   regs[magic_preg] == MAGIC (0 during INIT)
// BEHAVIOUR
// - Reset (rst low, async): FSM=INIT, sweep ptr=0, ready bits all 0, init_busy=1, dump_valid=0, dump_busy=0, dump_idx=0.
//   Data array is NOT reset; it is cleared by the sweep.
// - INIT: one preg/cycle, ptr 0..NUM_PREGS-1 written 0 (29->SP_INIT, 31->RA_INIT); ready[p]=(p<NUM_ARCH). Exactly NUM_PREGS cycles
//   after reset release, FSM=IDLE, init_busy=0. During INIT: wr_en/alloc_en/dump_start ignored, rd_data=0, rd_ready=0.
// - Reads (IDLE/DUMP): rd_data=regs[a], rd_ready=ready[a]; if any wr_en[w] with wr_addr[w]==a, data=wr_data[w], ready=1 (highest w wins).
//   Address 0: data 0, ready 1 always. Address >= NUM_PREGS: data 0, ready 0.
// - Writes: registered at posedge, zero-latency visible via bypass, next cycle via array. Writes to preg 0 discarded.
//   Duplicate wr_addr in one cycle: highest w wins (illegal upstream, must still be deterministic).
// - Ready: wr_en sets, alloc_en clears at posedge. Same preg set and cleared in one cycle: clear wins. Preg 0 ready forever.
// - Dump FSM: IDLE --dump_start--> DUMP (map latched, dump_idx=0, dump_valid=1 next cycle). Beat transfers when valid&&ready;
//   dump_idx increments; after idx NUM_ARCH-1 transfers -> IDLE, dump_valid=0. dump_data is combinational from current array
//   (not bypassed) and must be held stable by consumer only while valid&&!ready. dump_start while DUMP ignored.
//   Register writes/reads/allocs continue normally during DUMP. dump_busy=1 exactly in DUMP.
// - Reset asserted mid-INIT or mid-DUMP: immediate return to reset state; sweep restarts from 0.
// TESTING
// - Release reset, count cycles -> init_busy falls after exactly 96; rd preg 29 = SP_INIT, ready; rd preg 40: data 0, ready 0.
// - alloc preg 40, next cycle wr preg 40 = 0xDEADBEEF -> same-cycle rd preg 40 returns 0xDEADBEEF ready=1; next cycle from array.
// - Same cycle alloc_en+wr_en on preg 50 -> ready[50]=0 after edge; wr to preg 0 -> reads still 0.
// - dump_start, map arch2->preg 45 (=0x1234), dump_ready toggling 1/0 -> 32 beats idx 0..31, beat 2 data 0x1234, stalls held.
// - magic_preg=45, write MAGIC into 45 -> magic=1 next cycle; magic=0 throughout INIT.
// - Assert rst at sweep ptr 50 and mid-dump beat 10 -> outputs return to reset values; full 96-cycle sweep repeats.

Source files
------------

// File: rtl/phys_reg_file_sweep_if.sv
// Bundle of the register-file bus: read, writeback, allocate, dump and magic-compare signals.
// master = driver side (core / bench), slave = register file.
interface phys_reg_file_sweep_if #(
    parameter int unsigned NUM_PREGS   = 96,
    parameter int unsigned NUM_ARCH    = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned READ_PORTS  = 8,
    parameter int unsigned WRITE_PORTS = 4,
    parameter int unsigned ALLOC_PORTS = 4
);
    localparam int unsigned PB = $clog2(NUM_PREGS);
    localparam int unsigned AB = $clog2(NUM_ARCH);

    logic [READ_PORTS-1:0][PB-1:0]      rd_addr;
    logic [READ_PORTS-1:0][DATA_W-1:0]  rd_data;
    logic [READ_PORTS-1:0]              rd_ready;
    logic [WRITE_PORTS-1:0]             wr_en;
    logic [WRITE_PORTS-1:0][PB-1:0]     wr_addr;
    logic [WRITE_PORTS-1:0][DATA_W-1:0] wr_data;
    logic [ALLOC_PORTS-1:0]             alloc_en;
    logic [ALLOC_PORTS-1:0][PB-1:0]     alloc_addr;
    logic                               init_busy;
    logic                               dump_start;
    logic [NUM_ARCH-1:0][PB-1:0]        dump_map;
    logic                               dump_valid;
    logic                               dump_ready;
    logic [AB-1:0]                      dump_idx;
    logic [DATA_W-1:0]                  dump_data;
    logic                               dump_busy;
    logic [PB-1:0]                      magic_preg;
    logic                               magic;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output dump_start, dump_map, dump_ready, magic_preg,
        input  rd_data, rd_ready, init_busy, dump_valid, dump_idx, dump_data, dump_busy, magic
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  dump_start, dump_map, dump_ready, magic_preg,
        output rd_data, rd_ready, init_busy, dump_valid, dump_idx, dump_data, dump_busy, magic
    );
endinterface

// File: rtl/phys_reg_file_sweep.sv
// Physical register file with ready scoreboard, write bypass, post-reset clearing sweep
// and a handshaked architectural-state dump engine.
module phys_reg_file_sweep #(
    parameter int unsigned NUM_PREGS   = 96,
    parameter int unsigned NUM_ARCH    = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned READ_PORTS  = 8,
    parameter int unsigned WRITE_PORTS = 4,
    parameter int unsigned ALLOC_PORTS = 4,
    parameter logic [DATA_W-1:0] SP_INIT = '0,
    parameter logic [DATA_W-1:0] RA_INIT = '0,
    parameter logic [DATA_W-1:0] MAGIC   = '0
) (
    input logic                  clk,
    input logic                  rst,
    phys_reg_file_sweep_if.slave bus
);
    localparam int unsigned PB = $clog2(NUM_PREGS);
    localparam int unsigned AB = $clog2(NUM_ARCH);

    localparam logic [PB:0]   NPregs   = (PB + 1)'(NUM_PREGS);
    localparam logic [PB-1:0] LastPreg = PB'(NUM_PREGS - 1);
    localparam logic [PB-1:0] NArch    = PB'(NUM_ARCH);
    localparam logic [PB-1:0] SpPreg   = PB'(29);
    localparam logic [PB-1:0] RaPreg   = PB'(31);
    localparam logic [AB-1:0] LastArch = AB'(NUM_ARCH - 1);

    typedef enum logic [1:0] {StInit, StIdle, StDump} state_e;

    state_e                      state_q, state_d;
    logic [PB-1:0]               ptr_q, ptr_d;
    logic [AB-1:0]               idx_q, idx_d;
    logic [NUM_ARCH-1:0][PB-1:0] map_q, map_d;
    logic [NUM_PREGS-1:0]        ready_q, ready_d;
    logic [DATA_W-1:0]           regs_q [NUM_PREGS];
    logic [DATA_W-1:0]           regs_d [NUM_PREGS];
    logic [PB-1:0]               dump_preg;

    function automatic logic in_range(input logic [PB-1:0] a);
        return {1'b0, a} < NPregs;
    endfunction

    // Array and scoreboard next state: sweep during init, otherwise writeback then alloc (clear wins)
    always_comb begin
        regs_d  = regs_q;
        ready_d = ready_q;
        if (state_q == StInit) begin
            regs_d[ptr_q]  = (ptr_q == SpPreg) ? SP_INIT : (ptr_q == RaPreg) ? RA_INIT : '0;
            ready_d[ptr_q] = ptr_q < NArch;
        end else begin
            // Ascending loop lets the highest write port win on duplicate addresses
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (bus.wr_en[w] && in_range(bus.wr_addr[w]) && bus.wr_addr[w] != '0) begin
                    regs_d[bus.wr_addr[w]]  = bus.wr_data[w];
                    ready_d[bus.wr_addr[w]] = 1'b1;
                end
            end
            for (int a = 0; a < ALLOC_PORTS; a++) begin
                if (bus.alloc_en[a] && in_range(bus.alloc_addr[a]) && bus.alloc_addr[a] != '0) begin
                    ready_d[bus.alloc_addr[a]] = 1'b0;
                end
            end
        end
    end

    // Data array deliberately has no reset; the sweep clears it
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Control state, scoreboard and dump map registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            ptr_q   <= '0;
            idx_q   <= '0;
            map_q   <= '0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            map_q   <= map_d;
            ready_q <= ready_d;
        end
    end

    // Init / idle / dump sequencing
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        map_d   = map_q;
        unique case (state_q)
            StInit: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastPreg) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end
            end
            StIdle: begin
                if (bus.dump_start) begin
                    state_d = StDump;
                    map_d   = bus.dump_map;
                    idx_d   = '0;
                end
            end
            StDump: begin
                if (bus.dump_ready) begin
                    if (idx_q == LastArch) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Status, dump beat and magic-compare outputs
    always_comb begin
        dump_preg      = map_q[idx_q];
        bus.init_busy  = state_q == StInit;
        bus.dump_busy  = state_q == StDump;
        bus.dump_valid = state_q == StDump;
        bus.dump_idx   = idx_q;
        bus.dump_data  = in_range(dump_preg) ? regs_q[dump_preg] : '0;
        bus.magic      = (state_q != StInit) && in_range(bus.magic_preg) &&
                         (regs_q[bus.magic_preg] == MAGIC);
    end

    // Read ports with same-cycle writeback bypass
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            bus.rd_data[r]  = '0;
            bus.rd_ready[r] = 1'b0;
            if (state_q != StInit) begin
                if (bus.rd_addr[r] == '0) begin
                    bus.rd_ready[r] = 1'b1;
                end else if (in_range(bus.rd_addr[r])) begin
                    bus.rd_data[r]  = regs_q[bus.rd_addr[r]];
                    bus.rd_ready[r] = ready_q[bus.rd_addr[r]];
                    for (int w = 0; w < WRITE_PORTS; w++) begin
                        if (bus.wr_en[w] && bus.wr_addr[w] == bus.rd_addr[r]) begin
                            bus.rd_data[r]  = bus.wr_data[w];
                            bus.rd_ready[r] = 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
